// File: rtl/light_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : light_sequencer                                                 |
// | Brief    : Traffic-light phase controller with per-phase dwell timer,      |
// |            one-shot green extension and bounded green hold.                |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module light_sequencer #(
  parameter int CW        = 5,
  parameter int T_GREEN   = 8,
  parameter int T_YELLOW  = 3,
  parameter int T_EXT     = 4,
  parameter int T_MAXHOLD = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       mode,
  input  logic       delay,
  output logic [1:0] state,
  output logic       full,
  output logic [2:0] main_light,
  output logic [2:0] side_light
);

  typedef enum logic [1:0] {
    S_MAIN_G = 2'b00,
    S_MAIN_Y = 2'b01,
    S_SIDE_G = 2'b10,
    S_SIDE_Y = 2'b11
  } phase_t;

  localparam logic [CW-1:0] C_T_GREEN   = CW'(T_GREEN);
  localparam logic [CW-1:0] C_T_YELLOW  = CW'(T_YELLOW);
  localparam logic [CW-1:0] C_T_EXT     = CW'(T_EXT);
  localparam logic [CW-1:0] C_T_MAXHOLD = CW'(T_MAXHOLD);
  localparam logic [CW-1:0] C_CNT_MAX   = {CW{1'b1}};

  localparam logic [2:0] C_LAMP_RED    = 3'b100;
  localparam logic [2:0] C_LAMP_YELLOW = 3'b010;
  localparam logic [2:0] C_LAMP_GREEN  = 3'b001;

  phase_t        r_state;
  phase_t        w_state_nxt;
  logic [CW-1:0] r_timer;
  logic [CW-1:0] w_timer_nxt;
  logic          r_armed;
  logic          w_armed_nxt;
  logic          r_ext_used;
  logic          w_ext_used_nxt;
  logic [CW-1:0] r_hold_cnt;
  logic [CW-1:0] w_hold_cnt_nxt;

  logic          w_is_yellow;
  logic [CW-1:0] w_limit;
  logic          w_full;
  logic          w_advance;

  assign w_is_yellow = (r_state == S_MAIN_Y) || (r_state == S_SIDE_Y);
  assign w_limit     = w_is_yellow ? C_T_YELLOW : C_T_GREEN;
  assign w_full      = (r_timer == w_limit);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_MAIN_G;
      r_timer    <= '0;
      r_armed    <= 1'b0;
      r_ext_used <= 1'b0;
      r_hold_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_timer    <= w_timer_nxt;
      r_armed    <= w_armed_nxt;
      r_ext_used <= w_ext_used_nxt;
      r_hold_cnt <= w_hold_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_timer_nxt    = r_timer;
    w_armed_nxt    = r_armed;
    w_ext_used_nxt = r_ext_used;
    w_hold_cnt_nxt = r_hold_cnt;
    w_advance      = 1'b0;

    if (r_timer < w_limit) begin
      w_timer_nxt = r_timer + 1'b1;
    end else if (w_full) begin
      if (!r_armed) begin
        // Arm cycle: mode/delay reflect this phase only one cycle later.
        w_armed_nxt = 1'b1;
      end else if (w_is_yellow || mode || (r_hold_cnt == C_T_MAXHOLD)) begin
        w_advance = 1'b1;
      end else if (delay && !r_ext_used) begin
        w_timer_nxt    = w_limit - C_T_EXT;
        w_armed_nxt    = 1'b0;
        w_ext_used_nxt = 1'b1;
      end else if (delay) begin
        w_advance = 1'b1;
      end else if (r_hold_cnt != C_CNT_MAX) begin
        w_hold_cnt_nxt = r_hold_cnt + 1'b1;
      end
    end

    if (w_advance) begin
      w_state_nxt    = phase_t'(r_state + 2'd1);
      w_timer_nxt    = '0;
      w_armed_nxt    = 1'b0;
      w_ext_used_nxt = 1'b0;
      w_hold_cnt_nxt = '0;
    end
  end

  always_comb begin
    main_light = C_LAMP_RED;
    side_light = C_LAMP_RED;
    case (r_state)
      S_MAIN_G: main_light = C_LAMP_GREEN;
      S_MAIN_Y: main_light = C_LAMP_YELLOW;
      S_SIDE_G: side_light = C_LAMP_GREEN;
      S_SIDE_Y: side_light = C_LAMP_YELLOW;
      default: begin
        main_light = C_LAMP_RED;
        side_light = C_LAMP_RED;
      end
    endcase
  end

  assign state = r_state;
  assign full  = w_full;

endmodule
`default_nettype wire

// File: tb/tb_light_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_light_sequencer                                              |
// | Brief    : Directed self-checking bench for light_sequencer.               |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_light_sequencer;

  logic       clk;
  logic       rst;
  logic       mode;
  logic       delay;
  logic [1:0] state;
  logic       full;
  logic [2:0] main_light;
  logic [2:0] side_light;

  int r_checks   = 0;
  int r_failures = 0;

  light_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .mode       (mode),
    .delay      (delay),
    .state      (state),
    .full       (full),
    .main_light (main_light),
    .side_light (side_light)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    r_checks++;
    if (got !== exp) begin
      r_failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [2:0] exp_main(input logic [1:0] s);
    case (s)
      2'b00:   return 3'b001;
      2'b01:   return 3'b010;
      default: return 3'b100;
    endcase
  endfunction

  function automatic logic [2:0] exp_side(input logic [1:0] s);
    case (s)
      2'b10:   return 3'b001;
      2'b11:   return 3'b010;
      default: return 3'b100;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Check n consecutive cycles with a fixed phase and full level, stepping after each.
  task automatic run(input string tag, input logic [1:0] st, input int n, input logic exp_full);
    for (int i = 0; i < n; i++) begin
      check({tag, ".state"}, 32'(state), 32'(st));
      check({tag, ".full"}, 32'(full), 32'(exp_full));
      check({tag, ".main"}, 32'(main_light), 32'(exp_main(st)));
      check({tag, ".side"}, 32'(side_light), 32'(exp_side(st)));
      step();
    end
  endtask

  initial begin
    rst   = 1'b1;
    mode  = 1'b0;
    delay = 1'b0;
    step();
    step();
    run("reset", 2'b00, 1, 1'b0);
    rst = 1'b0;

    // Free-running cycle: green 10 (full on last 2), yellow 5 (full on last 2).
    mode = 1'b1;
    run("cyc_mg", 2'b00, 8, 1'b0); run("cyc_mg", 2'b00, 2, 1'b1);
    run("cyc_my", 2'b01, 3, 1'b0); run("cyc_my", 2'b01, 2, 1'b1);
    run("cyc_sg", 2'b10, 8, 1'b0); run("cyc_sg", 2'b10, 2, 1'b1);
    run("cyc_sy", 2'b11, 3, 1'b0); run("cyc_sy", 2'b11, 2, 1'b1);
    run("cyc_wrap", 2'b00, 1, 1'b0);

    // Hold: arm at 8, holds at 9..14, advance at 15 -> full high 8 cycles.
    mode = 1'b0;
    run("hold_mg", 2'b00, 7, 1'b0);
    run("hold_mg", 2'b00, 7, 1'b1);
    mode = 1'b1;
    run("hold_rel", 2'b00, 1, 1'b1);
    run("hold_my", 2'b01, 3, 1'b0); run("hold_my", 2'b01, 2, 1'b1);

    // Extension: extend at 9 (timer->4), full low 10..13, arm 14, advance 15.
    mode  = 1'b0;
    delay = 1'b1;
    run("ext_sg", 2'b10, 8, 1'b0);
    run("ext_sg", 2'b10, 2, 1'b1);
    run("ext_reload", 2'b10, 4, 1'b0);
    run("ext_rearm", 2'b10, 2, 1'b1);
    run("ext_sy", 2'b11, 3, 1'b0); run("ext_sy", 2'b11, 2, 1'b1);

    // Forced advance: arm 8, 20 holds at 9..28, hold_cnt==20 forces advance at 29.
    delay = 1'b0;
    run("force_mg", 2'b00, 8, 1'b0);
    run("force_mg", 2'b00, 22, 1'b1);
    run("force_my", 2'b01, 3, 1'b0); run("force_my", 2'b01, 2, 1'b1);

    // Hold count survives an extension: 5 holds, extend, then 15 more holds.
    run("mix_sg", 2'b10, 8, 1'b0);
    run("mix_hold", 2'b10, 6, 1'b1);
    delay = 1'b1;
    run("mix_ext", 2'b10, 1, 1'b1);
    delay = 1'b0;
    run("mix_reload", 2'b10, 4, 1'b0);
    run("mix_force", 2'b10, 17, 1'b1);
    run("mix_sy", 2'b11, 3, 1'b0); run("mix_sy", 2'b11, 2, 1'b1);

    // Reach side green, start an extension, then reset between clock edges.
    mode = 1'b1;
    run("pre_mg", 2'b00, 8, 1'b0); run("pre_mg", 2'b00, 2, 1'b1);
    run("pre_my", 2'b01, 3, 1'b0); run("pre_my", 2'b01, 2, 1'b1);
    mode  = 1'b0;
    delay = 1'b1;
    run("pre_sg", 2'b10, 8, 1'b0);
    run("pre_sg", 2'b10, 2, 1'b1);
    run("pre_reload", 2'b10, 2, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check("arst.state", 32'(state), 32'h0);
    check("arst.full", 32'(full), 32'h0);
    check("arst.main", 32'(main_light), 32'h1);
    check("arst.side", 32'(side_light), 32'h4);
    step();
    run("arst_hold", 2'b00, 1, 1'b0);
    rst   = 1'b0;
    mode  = 1'b1;
    delay = 1'b0;
    run("post_mg", 2'b00, 8, 1'b0); run("post_mg", 2'b00, 2, 1'b1);
    run("post_my", 2'b01, 1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", r_checks, r_failures);
    $finish;
  end

endmodule
`default_nettype wire
